// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave front panel blocks.
//
// Contents:
//   BCD_W                    width of one BCD digit
//   KEYS                     number of keypad keys (digits 0-9)
//   DEBOUNCE_CYCLES_DEFAULT  default debounce length in system clock samples
//   kp_state_e               keypad debounce FSM states
//   onehot_to_bcd()          converts a one-hot key vector to its BCD digit

package microwave_pkg;

    localparam int BCD_W                   = 4;
    localparam int KEYS                    = 10;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 5;

    typedef enum logic [1:0] {
        KP_IDLE    = 2'd0,
        KP_CHECK   = 2'd1,
        KP_HELD    = 2'd2,
        KP_RELEASE = 2'd3
    } kp_state_e;

    // OR-ing the indices of all set bits gives the right answer for a
    // one-hot input.
    function automatic logic [BCD_W-1:0] onehot_to_bcd(input logic [KEYS-1:0] onehot);
        logic [BCD_W-1:0] bcd;
        bcd = '0;
        for (int i = 0; i < KEYS; i++) begin
            if (onehot[i]) begin
                bcd = bcd | BCD_W'(i);
            end
        end
        return bcd;
    endfunction

endpackage

// File: rtl/entry_shift_reg.sv
// Three-digit BCD entry register (M:ST). Each shift moves the digits one
// place left and inserts din as the new ones digit; the old minutes digit
// is dropped. flush clears all three digits and wins over shift.
//
// Ports:
//   clk, clearn        system clock, asynchronous active-low reset
//   shift              insert din on this edge
//   flush              clear the entry on this edge
//   din                BCD digit to insert
//   entry_min/tens/ones  registered BCD digits

module entry_shift_reg
    import microwave_pkg::*;
(
    input  logic             clk,
    input  logic             clearn,
    input  logic             shift,
    input  logic             flush,
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] entry_min,
    output logic [BCD_W-1:0] entry_tens,
    output logic [BCD_W-1:0] entry_ones
);

    logic [BCD_W-1:0] min_q,  min_d;
    logic [BCD_W-1:0] tens_q, tens_d;
    logic [BCD_W-1:0] ones_q, ones_d;

    always_comb begin
        min_d  = min_q;
        tens_d = tens_q;
        ones_d = ones_q;
        if (flush) begin
            min_d  = '0;
            tens_d = '0;
            ones_d = '0;
        end else if (shift) begin
            min_d  = tens_q;
            tens_d = ones_q;
            ones_d = din;
        end
    end

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            min_q  <= '0;
            tens_q <= '0;
            ones_q <= '0;
        end else begin
            min_q  <= min_d;
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign entry_min  = min_q;
    assign entry_tens = tens_q;
    assign entry_ones = ones_q;

endmodule

// File: rtl/keypad_entry.sv
// Keypad input stage: synchronizes the raw one-hot keypad, debounces it,
// rejects multi-key presses and assembles accepted digits into a 3-digit
// BCD entry for the timer.
//
// Ports:
//   clk, clearn     system clock, asynchronous active-low reset
//   keypad          raw keys, bit i = digit i, asynchronous to clk
//   enable          controller permits entry
//   flush           synchronous clear of the entry digits
//   digit           BCD value of the last accepted key
//   digit_valid     one-cycle pulse per accepted key
//   entry_min/tens/ones  assembled BCD entry
//   entry_nonzero   OR of all entry bits (combinational)
//   multi_key       high while a multi-key press is being rejected

module keypad_entry
    import microwave_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             clearn,
    input  logic [KEYS-1:0]  keypad,
    input  logic             enable,
    input  logic             flush,
    output logic [BCD_W-1:0] digit,
    output logic             digit_valid,
    output logic [BCD_W-1:0] entry_min,
    output logic [BCD_W-1:0] entry_tens,
    output logic [BCD_W-1:0] entry_ones,
    output logic             entry_nonzero,
    output logic             multi_key
);

    // A press is accepted on the edge that sees the DEBOUNCE_CYCLES-th
    // matching sample; a release needs DEBOUNCE_CYCLES-1 clean samples,
    // the first of which is consumed by the HELD -> RELEASE transition.
    localparam logic [7:0] CNT_ACCEPT  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] CNT_RELEASE = 8'(DEBOUNCE_CYCLES - 2);

    logic [KEYS-1:0]  s1_q, s1_d;
    logic [KEYS-1:0]  s2_q, s2_d;
    logic [KEYS-1:0]  cand_q, cand_d;
    logic [7:0]       cnt_q, cnt_d;
    kp_state_e        state_q, state_d;
    logic             multi_key_q, multi_key_d;
    logic [BCD_W-1:0] digit_q, digit_d;
    logic             digit_valid_q, digit_valid_d;

    logic             key_none;
    logic             key_multi;
    logic             key_one;
    logic [7:0]       cnt_inc;
    logic             accept;
    logic             shift_en;

    // Clearing the lowest set bit leaves something only if two or more
    // bits were set.
    assign key_none  = (s2_q == '0);
    assign key_multi = |(s2_q & (s2_q - KEYS'(1)));
    assign key_one   = !key_none && !key_multi;
    assign cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        s1_d          = keypad;
        s2_d          = s1_q;
        state_d       = state_q;
        cand_d        = cand_q;
        cnt_d         = cnt_q;
        multi_key_d   = multi_key_q;
        digit_d       = digit_q;
        digit_valid_d = 1'b0;
        accept        = 1'b0;

        case (state_q)
            KP_IDLE: begin
                if (key_one) begin
                    cand_d  = s2_q;
                    cnt_d   = 8'd1;
                    state_d = KP_CHECK;
                end else if (key_multi) begin
                    multi_key_d = 1'b1;
                    state_d     = KP_HELD;
                end
            end
            KP_CHECK: begin
                if (s2_q == cand_q) begin
                    if (cnt_q == CNT_ACCEPT) begin
                        accept  = 1'b1;
                        state_d = KP_HELD;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else if (key_one) begin
                    cand_d = s2_q;
                    cnt_d  = 8'd1;
                end else if (key_none) begin
                    state_d = KP_IDLE;
                end else begin
                    multi_key_d = 1'b1;
                    state_d     = KP_HELD;
                end
            end
            KP_HELD: begin
                if (key_none) begin
                    cnt_d   = 8'd1;
                    state_d = KP_RELEASE;
                end
            end
            KP_RELEASE: begin
                if (!key_none) begin
                    state_d = KP_HELD;
                end else if (cnt_q >= CNT_RELEASE) begin
                    multi_key_d = 1'b0;
                    state_d     = KP_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = KP_RELEASE;
            end
        endcase

        // A press accepted while entry is disabled is simply consumed;
        // a flush on the accept edge suppresses the pulse as well.
        if (accept && enable && !flush) begin
            digit_d       = onehot_to_bcd(cand_q);
            digit_valid_d = 1'b1;
        end
    end

    // Reset into RELEASE so a key held through reset must be released
    // cleanly before it can be accepted.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            s1_q          <= '0;
            s2_q          <= '0;
            cand_q        <= '0;
            cnt_q         <= '0;
            state_q       <= KP_RELEASE;
            multi_key_q   <= 1'b0;
            digit_q       <= '0;
            digit_valid_q <= 1'b0;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            multi_key_q   <= multi_key_d;
            digit_q       <= digit_d;
            digit_valid_q <= digit_valid_d;
        end
    end

    assign shift_en = accept && enable;

    entry_shift_reg u_entry (
        .clk        (clk),
        .clearn     (clearn),
        .shift      (shift_en),
        .flush      (flush),
        .din        (onehot_to_bcd(cand_q)),
        .entry_min  (entry_min),
        .entry_tens (entry_tens),
        .entry_ones (entry_ones)
    );

    assign digit         = digit_q;
    assign digit_valid   = digit_valid_q;
    assign multi_key     = multi_key_q;
    assign entry_nonzero = |{entry_min, entry_tens, entry_ones};

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry. Inputs change on the falling edge
// and outputs are observed on the falling edge. A key driven on the falling
// edge when cyc == t0 is first sampled at rising edge t0+1, so an accepted
// press pulses digit_valid after rising edge t0+1+DEB+1, seen at the
// falling edge with cyc == t0+DEB+2.

module tb_keypad_entry;

    localparam int DEB = 5;

    logic       clk    = 1'b0;
    logic       clearn = 1'b1;
    logic [9:0] keypad = '0;
    logic       enable = 1'b1;
    logic       flush  = 1'b0;
    logic [3:0] digit, entry_min, entry_tens, entry_ones;
    logic       digit_valid, entry_nonzero, multi_key;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulse_cyc[$];
    int pulse_dig[$];
    int exp_d[3];

    keypad_entry #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk           (clk),
        .clearn        (clearn),
        .keypad        (keypad),
        .enable        (enable),
        .flush         (flush),
        .digit         (digit),
        .digit_valid   (digit_valid),
        .entry_min     (entry_min),
        .entry_tens    (entry_tens),
        .entry_ones    (entry_ones),
        .entry_nonzero (entry_nonzero),
        .multi_key     (multi_key)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every observed digit_valid cycle with the digit presented.
    always @(negedge clk) begin
        if (digit_valid === 1'b1) begin
            pulse_cyc.push_back(cyc);
            pulse_dig.push_back(int'(digit));
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int mask_digit(input logic [9:0] m);
        for (int i = 0; i < 10; i++) begin
            if (m == (10'b1 << i)) return i;
        end
        return -1;
    endfunction

    function automatic logic [11:0] exp_entry();
        return {exp_d[0][3:0], exp_d[1][3:0], exp_d[2][3:0]};
    endfunction

    function automatic void model_shift(input int d);
        exp_d[0] = exp_d[1];
        exp_d[1] = exp_d[2];
        exp_d[2] = d;
    endfunction

    function automatic void model_clear();
        exp_d[0] = 0;
        exp_d[1] = 0;
        exp_d[2] = 0;
    endfunction

    function automatic void clear_log();
        pulse_cyc.delete();
        pulse_dig.delete();
    endfunction

    task automatic test_reset();
        @(negedge clk);
        clearn = 1'b0;
        wait_cycles(3);
        total++; if ({digit, entry_min, entry_tens, entry_ones} !== 16'h0) begin bad++; $display("[TB] FAIL reset_regs got=%h want=0000", {digit, entry_min, entry_tens, entry_ones}); end
        total++; if ({digit_valid, entry_nonzero, multi_key} !== 3'b000) begin bad++; $display("[TB] FAIL reset_flags got=%b want=000", {digit_valid, entry_nonzero, multi_key}); end
        clearn = 1'b1;
        wait_cycles(DEB + 5);
        total++; if ({digit_valid, entry_min, entry_tens, entry_ones} !== 13'h0) begin bad++; $display("[TB] FAIL reset_idle got=%h want=0", {digit_valid, entry_min, entry_tens, entry_ones}); end
        model_clear();
    endtask

    task automatic test_basic_entry();
        int keys[3] = '{2, 5, 9};
        int t0[3];
        clear_log();
        for (int i = 0; i < 3; i++) begin
            t0[i] = cyc;
            keypad = 10'b1 << keys[i];
            wait_cycles(110);
            keypad = '0;
            wait_cycles(110);
            model_shift(keys[i]);
        end
        total++;
        if (pulse_cyc.size() != 3) begin
            bad++; $display("[TB] FAIL basic_pulses got=%0d want=3", pulse_cyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++; if (pulse_cyc[i] != t0[i] + DEB + 2) begin bad++; $display("[TB] FAIL basic_latency got=%0d want=%0d", pulse_cyc[i], t0[i] + DEB + 2); end
                total++; if (pulse_dig[i] != keys[i]) begin bad++; $display("[TB] FAIL basic_pulse_digit got=%0d want=%0d", pulse_dig[i], keys[i]); end
            end
        end
        total++; if ({entry_min, entry_tens, entry_ones} !== 12'h259) begin bad++; $display("[TB] FAIL basic_entry got=%h want=259", {entry_min, entry_tens, entry_ones}); end
        total++; if (digit !== 4'd9) begin bad++; $display("[TB] FAIL basic_digit got=%0d want=9", digit); end
        total++; if (entry_nonzero !== 1'b1) begin bad++; $display("[TB] FAIL basic_nonzero got=%b want=1", entry_nonzero); end
    endtask

    task automatic test_shift_overflow();
        logic [11:0] want[2] = '{12'h599, 12'h999};
        for (int i = 0; i < 2; i++) begin
            clear_log();
            keypad = 10'b1 << 9;
            wait_cycles(40);
            keypad = '0;
            wait_cycles(40);
            model_shift(9);
            total++; if (pulse_cyc.size() != 1) begin bad++; $display("[TB] FAIL overflow_pulses got=%0d want=1", pulse_cyc.size()); end
            total++; if ({entry_min, entry_tens, entry_ones} !== want[i]) begin bad++; $display("[TB] FAIL overflow_entry got=%h want=%h", {entry_min, entry_tens, entry_ones}, want[i]); end
        end
    endtask

    task automatic test_bounce();
        clear_log();
        for (int i = 0; i < 5; i++) begin
            keypad = 10'b1 << 3;
            wait_cycles(2);
            keypad = '0;
            wait_cycles(2);
        end
        wait_cycles(20);
        total++; if (pulse_cyc.size() != 0) begin bad++; $display("[TB] FAIL bounce_pulses got=%0d want=0", pulse_cyc.size()); end
        total++; if ({entry_min, entry_tens, entry_ones} !== exp_entry()) begin bad++; $display("[TB] FAIL bounce_entry got=%h want=%h", {entry_min, entry_tens, entry_ones}, exp_entry()); end
    endtask

    task automatic test_multi_key();
        clear_log();
        keypad = (10'b1 << 4) | (10'b1 << 7);
        wait_cycles(10);
        total++; if (multi_key !== 1'b1) begin bad++; $display("[TB] FAIL multi_during got=%b want=1", multi_key); end
        wait_cycles(40);
        keypad = '0;
        // DEB-1 clean samples after the two-flop synchronizer.
        wait_cycles(2 + (DEB - 1) - 1);
        total++; if (multi_key !== 1'b1) begin bad++; $display("[TB] FAIL multi_early_clear got=%b want=1", multi_key); end
        wait_cycles(1);
        total++; if (multi_key !== 1'b0) begin bad++; $display("[TB] FAIL multi_clear got=%b want=0", multi_key); end
        wait_cycles(10);
        total++; if (pulse_cyc.size() != 0) begin bad++; $display("[TB] FAIL multi_pulses got=%0d want=0", pulse_cyc.size()); end
        total++; if ({entry_min, entry_tens, entry_ones} !== exp_entry()) begin bad++; $display("[TB] FAIL multi_entry got=%h want=%h", {entry_min, entry_tens, entry_ones}, exp_entry()); end
    endtask

    task automatic test_enable_gating();
        int t0;
        clear_log();
        enable = 1'b0;
        keypad = 10'b1 << 8;
        wait_cycles(20);
        enable = 1'b1;
        wait_cycles(20);
        keypad = '0;
        wait_cycles(30);
        total++; if (pulse_cyc.size() != 0) begin bad++; $display("[TB] FAIL enable_pulses got=%0d want=0", pulse_cyc.size()); end
        total++; if ({entry_min, entry_tens, entry_ones} !== exp_entry()) begin bad++; $display("[TB] FAIL enable_entry got=%h want=%h", {entry_min, entry_tens, entry_ones}, exp_entry()); end
        t0 = cyc;
        keypad = 10'b1 << 8;
        wait_cycles(30);
        keypad = '0;
        wait_cycles(30);
        model_shift(8);
        total++;
        if (pulse_cyc.size() != 1) begin
            bad++; $display("[TB] FAIL enable_repress_pulses got=%0d want=1", pulse_cyc.size());
        end else begin
            total++; if (pulse_cyc[0] != t0 + DEB + 2) begin bad++; $display("[TB] FAIL enable_repress_latency got=%0d want=%0d", pulse_cyc[0], t0 + DEB + 2); end
        end
        total++; if ({entry_min, entry_tens, entry_ones} !== 12'h998) begin bad++; $display("[TB] FAIL enable_repress_entry got=%h want=998", {entry_min, entry_tens, entry_ones}); end
        total++; if (digit !== 4'd8) begin bad++; $display("[TB] FAIL enable_repress_digit got=%0d want=8", digit); end
    endtask

    task automatic test_flush_collision();
        clear_log();
        keypad = 10'b1 << 1;
        wait_cycles(DEB + 1);
        flush = 1'b1;
        wait_cycles(1);
        flush = 1'b0;
        wait_cycles(30);
        keypad = '0;
        wait_cycles(20);
        model_clear();
        total++; if (pulse_cyc.size() != 0) begin bad++; $display("[TB] FAIL flush_pulses got=%0d want=0", pulse_cyc.size()); end
        total++; if ({entry_min, entry_tens, entry_ones} !== 12'h000) begin bad++; $display("[TB] FAIL flush_entry got=%h want=000", {entry_min, entry_tens, entry_ones}); end
        total++; if (entry_nonzero !== 1'b0) begin bad++; $display("[TB] FAIL flush_nonzero got=%b want=0", entry_nonzero); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            logic [9:0] mask;
            logic       en;
            int         k, hold, gap, t0, d;
            k    = $urandom_range(0, 9);
            mask = 10'b1 << k;
            if ($urandom_range(0, 5) == 0) mask = mask | (10'b1 << ((k + 1 + $urandom_range(0, 8)) % 10));
            en   = ($urandom_range(0, 3) != 0);
            hold = DEB + 1 + $urandom_range(0, 30);
            gap  = DEB + $urandom_range(0, 20);
            d    = mask_digit(mask);
            clear_log();
            enable = en;
            t0     = cyc;
            keypad = mask;
            wait_cycles(hold);
            keypad = '0;
            wait_cycles(gap);
            enable = 1'b1;
            if (d >= 0 && en) begin
                model_shift(d);
                total++;
                if (pulse_cyc.size() != 1) begin
                    bad++; $display("[TB] FAIL rand_pulses got=%0d want=1 mask=%b", pulse_cyc.size(), mask);
                end else begin
                    total++; if (pulse_cyc[0] != t0 + DEB + 2) begin bad++; $display("[TB] FAIL rand_latency got=%0d want=%0d", pulse_cyc[0], t0 + DEB + 2); end
                    total++; if (pulse_dig[0] != d) begin bad++; $display("[TB] FAIL rand_digit got=%0d want=%0d", pulse_dig[0], d); end
                end
            end else begin
                total++; if (pulse_cyc.size() != 0) begin bad++; $display("[TB] FAIL rand_no_pulse got=%0d want=0 mask=%b en=%b", pulse_cyc.size(), mask, en); end
            end
            total++; if ({entry_min, entry_tens, entry_ones} !== exp_entry()) begin bad++; $display("[TB] FAIL rand_entry got=%h want=%h", {entry_min, entry_tens, entry_ones}, exp_entry()); end
            if ($urandom_range(0, 5) == 0) begin
                flush = 1'b1;
                wait_cycles(1);
                flush = 1'b0;
                wait_cycles(1);
                model_clear();
                total++; if ({entry_min, entry_tens, entry_ones, entry_nonzero} !== 13'h0) begin bad++; $display("[TB] FAIL rand_flush got=%h want=0", {entry_min, entry_tens, entry_ones, entry_nonzero}); end
            end
        end
    endtask

    task automatic test_reset_held_key();
        int t0;
        clear_log();
        keypad = 10'b1 << 6;
        wait_cycles(3);
        clearn = 1'b0;
        wait_cycles(3);
        clearn = 1'b1;
        model_clear();
        wait_cycles(40);
        total++; if (pulse_cyc.size() != 0) begin bad++; $display("[TB] FAIL held_reset_pulses got=%0d want=0", pulse_cyc.size()); end
        total++; if ({entry_min, entry_tens, entry_ones} !== 12'h000) begin bad++; $display("[TB] FAIL held_reset_entry got=%h want=000", {entry_min, entry_tens, entry_ones}); end
        keypad = '0;
        wait_cycles(20);
        t0 = cyc;
        keypad = 10'b1 << 6;
        wait_cycles(30);
        keypad = '0;
        wait_cycles(20);
        model_shift(6);
        total++;
        if (pulse_cyc.size() != 1) begin
            bad++; $display("[TB] FAIL held_repress_pulses got=%0d want=1", pulse_cyc.size());
        end else begin
            total++; if (pulse_cyc[0] != t0 + DEB + 2) begin bad++; $display("[TB] FAIL held_repress_latency got=%0d want=%0d", pulse_cyc[0], t0 + DEB + 2); end
        end
        total++; if ({digit, entry_min, entry_tens, entry_ones} !== 16'h6006) begin bad++; $display("[TB] FAIL held_repress_regs got=%h want=6006", {digit, entry_min, entry_tens, entry_ones}); end
    endtask

    task automatic test_async_reset();
        keypad = 10'b1 << 3;
        wait_cycles(4);
        #2;
        clearn = 1'b0;
        #1;
        total++; if ({digit, entry_min, entry_tens, entry_ones} !== 16'h0) begin bad++; $display("[TB] FAIL async_regs got=%h want=0000", {digit, entry_min, entry_tens, entry_ones}); end
        total++; if ({digit_valid, entry_nonzero, multi_key} !== 3'b000) begin bad++; $display("[TB] FAIL async_flags got=%b want=000", {digit_valid, entry_nonzero, multi_key}); end
        keypad = '0;
        @(negedge clk);
        clearn = 1'b1;
        model_clear();
        wait_cycles(10);
    endtask

    initial begin
        test_reset();
        test_basic_entry();
        test_shift_overflow();
        test_bounce();
        test_multi_key();
        test_enable_gating();
        test_flush_collision();
        test_random();
        test_reset_held_key();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Input stage directly upstream of the microwave controller/timer: conditions the raw 10-bit one-hot keypad, debounces it, rejects multi-key presses, and assembles accepted digits into a 3-digit BCD entry (M:ST) for the timer to load on start. Each accepted keystroke produces a one-cycle `digit_valid` pulse. The block runs on the system clock and is cleared by the system clear.

## Interface
- `DEBOUNCE_CYCLES`, default 5: consecutive synchronized samples a key state must hold (50 ms at the 100 Hz system clock); legal range 2–255.
- `clk`  in  1  system clock, rising edge.
- `clearn`  in  1  asynchronous, active-low reset.
- `keypad`  in  10  raw keys; bit i = digit i; asynchronous to `clk`.
- `enable`  in  1  controller permits entry; low while cooking or paused.
- `flush`  in  1  synchronous clear of the entry digits; asserted by the controller on stop-while-idle and after timer load.
- `digit`  out  4  BCD value of the last accepted key.
- `digit_valid`  out  1  one-cycle pulse per accepted key.
- `entry_min`, `entry_tens`, `entry_ones`  out  4 each  assembled BCD entry.
- `entry_nonzero`  out  1  OR of all entry bits (combinational from the entry registers).
- `multi_key`  out  1  high while the FSM is rejecting a multi-key press.

## Operation
- Synchronizer: `keypad` passes through two flops, `s1` then `s2`. The FSM sees only `s2`.
- Classification of `s2`:
  - NONE: all zero.
  - ONE: exactly one bit set.
  - MULTI: two or more bits set.
- FSM states: IDLE, CHECK, HELD, RELEASE. A counter `cnt` is 8 bits wide and saturates.
- IDLE:
  - NONE: stay.
  - ONE: latch `cand` ← `s2`, set `cnt` ← 1, go to CHECK.
  - MULTI: go to HELD and set `multi_key`.
- CHECK:
  - `s2` == `cand`: increment `cnt`. When `cnt` == DEBOUNCE_CYCLES−1 on this edge, the key is accepted and the FSM goes to HELD.
  - `s2` is ONE but differs from `cand`: restart with the new `cand` and `cnt` ← 1.
  - `s2` is NONE: go to IDLE.
  - `s2` is MULTI: go to HELD and set `multi_key`.
- HELD:
  - Any key set: stay.
  - NONE: set `cnt` ← 1 and go to RELEASE.
- RELEASE:
  - NONE: increment `cnt`. At DEBOUNCE_CYCLES−1, go to IDLE and clear `multi_key`.
  - Any key set: go back to HELD.
- Accept action, only when `enable` = 1:
  - `digit` ← encode(`cand`).
  - `digit_valid` ← 1 for one cycle.
  - Shift: `entry_min` ← `entry_tens`, `entry_tens` ← `entry_ones`, `entry_ones` ← new digit. The old `entry_min` is discarded.
- Acceptance with `enable` = 0: the press is consumed (FSM still goes to HELD). No pulse, no shift, `digit` unchanged. A key held while `enable` rises is never accepted; it must be released and pressed again.
- Digits are stored as raw BCD. `entry_tens` > 5 is legal here; normalization belongs to the timer.
- `flush` priority: `flush` beats an accept on the same edge. The entry registers clear to 0, `digit_valid` stays 0, and the FSM still goes to HELD.

## Timing
- Reset values:
  - All outputs are 0.
  - `s1` and `s2` are 0.
  - `cand` and `cnt` are 0.
  - FSM state is RELEASE, so a key held through reset is ignored until a clean release is seen.
- After `clearn` deasserts with keypad idle, the FSM reaches IDLE at the DEBOUNCE_CYCLES−1th rising edge.
- Press latency:
  - Setup: keypad stable one-hot, first sampled at edge 0, FSM in IDLE, `enable` = 1.
  - `digit_valid` is high for exactly the cycle after edge DEBOUNCE_CYCLES+1.
  - With the default of 5, it is high after edge 6 (60 ms).
- `digit` and the entry registers update on that same edge and hold until the next accept, `flush`, or reset.
- Minimum key period: a release must be stable for DEBOUNCE_CYCLES−1 samples before the next press starts counting.
- All outputs are registered except `entry_nonzero`.

## Structure
- Shared package `microwave_pkg`:
  - FSM state enum.
  - `BCD_W` = 4.
  - `KEYS` = 10.
  - Default `DEBOUNCE_CYCLES`.
  - Function `onehot_to_bcd`.
- Sub-module `entry_shift_reg`: the 3-digit BCD shift register with `shift`, `din`, and `flush` inputs. The synchronizer, classifier, and FSM stay in the top level.

## Test plan
- Basic entry: reset, then press 2, 5, 9, each held 110 cycles with 110 cycles gap. Expect:
  - Exactly 3 `digit_valid` pulses.
  - Entry ends at 2:59.
  - `digit` = 9.
  - `entry_nonzero` = 1.
- Shift overflow: from 2:59, press 9 twice. Expect entry 5:99 then 9:99; the leading 2 is discarded.
- Bounce and multi-key:
  - Toggle key 3 on/off every 2 cycles for 20 cycles, then release: no pulse.
  - Press keys 4 and 7 together for 50 cycles: `multi_key` = 1 during the press, no pulse, entry unchanged, and `multi_key` clears 4 cycles after release.
- Enable gating:
  - With `enable` = 0, press 8: no pulse, entry unchanged.
  - Raise `enable` while 8 is still held: still no pulse.
  - Release, then press 8 again: one pulse, and 8 shifts in.
- Flush collision: assert `flush` on the exact accept edge of key 1. Expect entry 0:00, no pulse, and `entry_nonzero` = 0.
- Reset behaviour:
  - Hold key 6 through `clearn`: no pulse after release of reset, until key 6 is released and pressed again.
  - Pulse `clearn` mid-CHECK: all outputs drop to 0 asynchronously.
